// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state type and default geometry/timing.
package instr_fetch_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam int unsigned DEF_OPC_W    = 4;
  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_TIMEOUT  = 15;
  localparam int unsigned CNT_W        = 8;

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: load has priority over increment, both gated by en.
module pc_counter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (en && load) begin
      pc <= target;
    end else if (en && inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC/IR ownership and req/ready instruction fetch with timeout fault.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned INSTR_W  = DEF_INSTR_W,
  parameter int unsigned OPC_W    = DEF_OPC_W,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     loadIR,
  input  logic                     loadPC,
  input  logic                     incPC,
  input  logic [ADDR_W-1:0]        pc_target,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ready,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic [ADDR_W-1:0]        pc,
  output logic [INSTR_W-1:0]       ir,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic                     ir_valid,
  output logic                     busy,
  output logic                     fault
);

  fetch_state_t     state;
  logic [CNT_W-1:0] cnt;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (loadPC),
    .inc    (incPC),
    .target (pc_target),
    .pc     (pc)
  );

  // imem_addr samples the pre-update pc, so same-edge incPC/loadPC never leak into the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && loadIR) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            ir_valid  <= 1'b0;
            fault     <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            imem_req <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign opcode  = ir[INSTR_W-1 -: OPC_W];
  assign operand = ir[INSTR_W-OPC_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, en, loadIR, loadPC, incPC;
  logic [7:0]  pc_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        ir_valid, busy, fault;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned req_cycles;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (8),
    .INSTR_W  (16),
    .OPC_W    (4),
    .RESET_PC (0),
    .TIMEOUT  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .loadIR     (loadIR),
    .loadPC     (loadPC),
    .incPC      (incPC),
    .pc_target  (pc_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .operand    (operand),
    .ir_valid   (ir_valid),
    .busy       (busy),
    .fault      (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; loadIR = 1'b0; loadPC = 1'b0; incPC = 1'b0;
    pc_target = '0; imem_ready = 1'b0; imem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_ir", 32'(ir), 32'h0000);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_fault", 32'(fault), 32'h0);

    // 1: single-cycle fetch with ready tied high
    imem_ready = 1'b1; imem_rdata = 16'h9ABC; loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    check("t1_req", 32'(imem_req), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_addr", 32'(imem_addr), 32'h00);
    tick();
    check("t1_req_drop", 32'(imem_req), 32'h0);
    check("t1_ir", 32'(ir), 32'h9ABC);
    check("t1_opcode", 32'(opcode), 32'h9);
    check("t1_operand", 32'(operand), 32'hABC);
    check("t1_valid", 32'(ir_valid), 32'h1);

    // 2: slow memory, PC changes while waiting
    imem_ready = 1'b0; imem_rdata = 16'h1234; loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    check("t2_req", 32'(imem_req), 32'h1);
    check("t2_valid_clr", 32'(ir_valid), 32'h0);
    incPC = 1'b1;
    tick();
    incPC = 1'b0;
    check("t2_pc_inc", 32'(pc), 32'h01);
    loadPC = 1'b1; pc_target = 8'h40;
    tick();
    loadPC = 1'b0;
    check("t2_addr_stable", 32'(imem_addr), 32'h00);
    check("t2_pc_load", 32'(pc), 32'h40);
    tick();
    tick();
    check("t2_still_wait", 32'(imem_req), 32'h1);
    imem_ready = 1'b1;
    tick();
    imem_rdata = 16'h5555;
    check("t2_ir", 32'(ir), 32'h1234);
    check("t2_valid", 32'(ir_valid), 32'h1);
    check("t2_req_drop", 32'(imem_req), 32'h0);
    tick();
    imem_ready = 1'b0;
    check("t2_idle_ready_ignored", 32'(ir), 32'h1234);
    check("t2_idle_no_req", 32'(imem_req), 32'h0);

    // 3: timeout
    loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    check("t3_addr", 32'(imem_addr), 32'h40);
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!imem_req) break;
      req_cycles++;
      tick();
    end
    check("t3_req_cycles", 32'(req_cycles), 32'd15);
    check("t3_fault", 32'(fault), 32'h1);
    check("t3_ir_kept", 32'(ir), 32'h1234);
    check("t3_valid", 32'(ir_valid), 32'h0);
    check("t3_busy", 32'(busy), 32'h0);
    imem_ready = 1'b1; imem_rdata = 16'hF00D; loadIR = 1'b1;
    tick();
    loadIR = 1'b0;
    check("t3_fault_clr", 32'(fault), 32'h0);
    tick();
    imem_ready = 1'b0;
    check("t3_refetch", 32'(ir), 32'hF00D);

    // 4: PC wrap and load priority
    loadPC = 1'b1; pc_target = 8'hFF;
    tick();
    loadPC = 1'b0;
    check("t4_pc_ff", 32'(pc), 32'hFF);
    incPC = 1'b1;
    tick();
    check("t4_wrap", 32'(pc), 32'h00);
    loadPC = 1'b1; pc_target = 8'h12;
    tick();
    loadPC = 1'b0; incPC = 1'b0;
    check("t4_load_wins", 32'(pc), 32'h12);

    // same-edge loadIR & incPC: fetch uses pre-increment PC
    loadIR = 1'b1; incPC = 1'b1;
    tick();
    loadIR = 1'b0; incPC = 1'b0;
    check("t4_preinc_addr", 32'(imem_addr), 32'h12);
    check("t4_preinc_pc", 32'(pc), 32'h13);

    // 5: reset mid-WAIT with ready on the same edge
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    rst = 1'b0; imem_ready = 1'b0;
    check("t5_ir", 32'(ir), 32'h0000);
    check("t5_valid", 32'(ir_valid), 32'h0);
    check("t5_req", 32'(imem_req), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_pc", 32'(pc), 32'h00);
    check("t5_addr", 32'(imem_addr), 32'h00);

    // 6: en low masks all strobes
    en = 1'b0; loadIR = 1'b1; incPC = 1'b1;
    tick();
    tick();
    loadIR = 1'b0; incPC = 1'b0; loadPC = 1'b1; pc_target = 8'h77;
    tick();
    loadPC = 1'b0;
    check("t6_req", 32'(imem_req), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_pc", 32'(pc), 32'h00);
    en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
